// File: rtl/phy_rx_deserializador_if.sv
// Parallel-side bundle of the PHY receive lane: serial bit in, assembled words
// and lane status out. The deserializer is the master of the parallel outputs.
interface phy_rx_deserializador_if;
   logic        data_in;
   logic [31:0] data_output;
   logic        valid_out;
   logic        active;
   logic        error;

   modport master (
      input  data_in,
      output data_output,
      output valid_out,
      output active,
      output error
   );

   modport slave (
      output data_in,
      input  data_output,
      input  valid_out,
      input  active,
      input  error
   );
endinterface

// File: rtl/phy_rx_deserializador.sv
// PHY serial receive: bit-level comma hunt, byte alignment/lock on BC_COUNT
// aligned commas, then MSB-first byte packing into 32-bit words.
module phy_rx_deserializador #(
   parameter int unsigned BC_COUNT = 4,
   parameter logic [7:0]  BC_BYTE  = 8'hBC
) (
   input  logic                           clk_32f,
   input  logic                           reset,
   phy_rx_deserializador_if.master        lane
);

   localparam int unsigned BCW = $clog2(BC_COUNT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          r_state;
   logic [7:0]      r_sr;
   logic [2:0]      r_bit_cnt;
   logic [BCW-1:0]  r_bc_cnt;
   logic [1:0]      r_byte_idx;
   logic [23:0]     r_partial;
   logic [31:0]     r_data_output;
   logic            r_valid;
   logic            r_active;
   logic            r_error;

   state_t          w_next_state;
   logic [2:0]      w_next_bit_cnt;
   logic [BCW-1:0]  w_next_bc_cnt;
   logic [BCW-1:0]  w_bc_inc;
   logic [1:0]      w_next_byte_idx;
   logic [23:0]     w_next_partial;
   logic [31:0]     w_next_data;
   logic            w_next_valid;
   logic            w_next_active;
   logic            w_next_error;
   logic [7:0]      w_cur;
   logic            w_is_bc;
   logic            w_boundary;

   // Candidate byte including the bit being sampled this cycle
   assign w_cur      = {r_sr[6:0], lane.data_in};
   assign w_is_bc    = (w_cur == BC_BYTE);
   assign w_boundary = (r_bit_cnt == 3'd7);
   assign w_bc_inc   = r_bc_cnt + BCW'(1);

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_state       <= HUNT;
         r_sr          <= 8'h00;
         r_bit_cnt     <= 3'd0;
         r_bc_cnt      <= '0;
         r_byte_idx    <= 2'd0;
         r_partial     <= 24'h0;
         r_data_output <= 32'h0;
         r_valid       <= 1'b0;
         r_active      <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_sr          <= w_cur;
         r_bit_cnt     <= w_next_bit_cnt;
         r_bc_cnt      <= w_next_bc_cnt;
         r_byte_idx    <= w_next_byte_idx;
         r_partial     <= w_next_partial;
         r_data_output <= w_next_data;
         r_valid       <= w_next_valid;
         r_active      <= w_next_active;
         r_error       <= w_next_error;
      end
   end

   // Next state, counters and output pulses
   always_comb begin
      w_next_state    = r_state;
      w_next_bit_cnt  = r_bit_cnt + 3'd1;
      w_next_bc_cnt   = r_bc_cnt;
      w_next_byte_idx = r_byte_idx;
      w_next_partial  = r_partial;
      w_next_data     = r_data_output;
      w_next_valid    = 1'b0;
      w_next_error    = 1'b0;

      case (r_state)
         HUNT: begin
            if (w_is_bc) begin
               w_next_bit_cnt = 3'd0;
               w_next_bc_cnt  = BCW'(1);
               w_next_state   = (BC_COUNT == 1) ? LOCKED : ALIGN;
            end
         end
         ALIGN: begin
            if (w_boundary) begin
               if (w_is_bc) begin
                  w_next_bc_cnt = w_bc_inc;
                  if (w_bc_inc == BCW'(BC_COUNT)) begin
                     w_next_state = LOCKED;
                  end
               end else begin
                  w_next_bc_cnt = '0;
                  w_next_state  = HUNT;
               end
            end
         end
         LOCKED: begin
            if (w_boundary) begin
               if (w_is_bc) begin
                  // Idle comma: a half-built word cannot be completed
                  if (r_byte_idx != 2'd0) begin
                     w_next_byte_idx = 2'd0;
                     w_next_error    = 1'b1;
                  end
               end else if (r_byte_idx == 2'd3) begin
                  w_next_data     = {r_partial, w_cur};
                  w_next_valid    = 1'b1;
                  w_next_byte_idx = 2'd0;
               end else begin
                  w_next_partial  = {r_partial[15:0], w_cur};
                  w_next_byte_idx = r_byte_idx + 2'd1;
               end
            end
         end
         default: begin
            w_next_state = HUNT;
         end
      endcase

      w_next_active = (w_next_state == LOCKED);
   end

   assign lane.data_output = r_data_output;
   assign lane.valid_out   = r_valid;
   assign lane.active      = r_active;
   assign lane.error       = r_error;

endmodule

// File: tb/tb_phy_rx_deserializador.sv
// Bench for phy_rx_deserializador: directed and random bit streams compared
// cycle by cycle against an array-scanning reference of the lane protocol.
module tb_phy_rx_deserializador;

   localparam int unsigned BC_COUNT = 4;
   localparam logic [7:0]  BC       = 8'hBC;

   logic clk_32f = 1'b0;
   logic reset   = 1'b1;

   phy_rx_deserializador_if lane ();

   phy_rx_deserializador #(
      .BC_COUNT (BC_COUNT),
      .BC_BYTE  (BC)
   ) dut (
      .clk_32f (clk_32f),
      .reset   (reset),
      .lane    (lane)
   );

   always #5 clk_32f = ~clk_32f;

   int n_chk  = 0;
   int n_pass = 0;

   bit          seg_bits[$];
   logic [2:0]  obs_flags[$];   // {valid_out, active, error}
   logic [31:0] obs_data[$];
   logic [2:0]  exp_flags[$];
   logic [31:0] exp_data[$];
   logic [31:0] obs_words[$];
   int          obs_vtimes[$];
   int          obs_nerr;
   int          obs_first_act;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int k = 7; k >= 0; k--) seg_bits.push_back(b[k]);
   endtask

   task automatic push_commas(input int n);
      for (int i = 0; i < n; i++) push_byte(BC);
   endtask

   // Byte formed by the 8 bits ending at index p (zeros before the segment start)
   function automatic logic [7:0] win(input int p);
      logic [7:0] w = 8'h00;
      for (int k = p - 7; k <= p; k++)
         w = {w[6:0], (k >= 0 && k < seg_bits.size()) ? seg_bits[k] : 1'b0};
      return w;
   endfunction

   // Reference: scan the stream for the lock point, then walk aligned bytes
   task automatic run_model();
      int          n;
      int          lock_end;
      int          p;
      int          q;
      int          cnt;
      int          k;
      logic [31:0] acc;
      logic [31:0] last;
      logic [7:0]  b;
      bit          ev_valid[];
      bit          ev_err[];
      logic [31:0] ev_word[];
      bit          act;
      n        = seg_bits.size();
      lock_end = -1;
      p        = 0;
      ev_valid = new[n];
      ev_err   = new[n];
      ev_word  = new[n];
      while (p < n && lock_end < 0) begin
         if (win(p) == BC) begin
            cnt = 1;
            q   = p;
            while (cnt < int'(BC_COUNT) && q + 8 < n && win(q + 8) == BC) begin
               cnt++;
               q += 8;
            end
            if (cnt == int'(BC_COUNT)) lock_end = q;
            else if (q + 8 < n) p = q + 9;
            else p = n;
         end else begin
            p++;
         end
      end
      if (lock_end >= 0) begin
         k   = 0;
         acc = 32'h0;
         for (int e = lock_end + 8; e < n; e += 8) begin
            b = win(e);
            if (b == BC) begin
               if (k != 0) ev_err[e] = 1'b1;
               k = 0;
            end else begin
               acc = {acc[23:0], b};
               k++;
               if (k == 4) begin
                  ev_valid[e] = 1'b1;
                  ev_word[e]  = acc;
                  k = 0;
               end
            end
         end
      end
      exp_flags.delete();
      exp_data.delete();
      last = 32'h0;
      for (int t = 0; t < n; t++) begin
         act = (lock_end >= 0) && (t >= lock_end);
         if (ev_valid[t]) last = ev_word[t];
         exp_flags.push_back({ev_valid[t], act, ev_err[t]});
         exp_data.push_back(last);
      end
   endtask

   // Three reset cycles with a toggling serial input; ends at a negedge
   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_32f);
         lane.data_in = ~lane.data_in;
         @(posedge clk_32f);
         #1;
         chk("rst_flags", 32'({lane.valid_out, lane.active, lane.error}), 32'h0);
         chk("rst_data", lane.data_output, 32'h0);
      end
      @(negedge clk_32f);
      reset = 1'b0;
   endtask

   // Reset, play seg_bits, then compare every cycle with the reference
   task automatic run_segment(input string name);
      do_reset();
      obs_flags.delete();
      obs_data.delete();
      obs_words.delete();
      obs_vtimes.delete();
      obs_nerr      = 0;
      obs_first_act = -1;
      for (int t = 0; t < seg_bits.size(); t++) begin
         lane.data_in = seg_bits[t];
         @(posedge clk_32f);
         #1;
         obs_flags.push_back({lane.valid_out, lane.active, lane.error});
         obs_data.push_back(lane.data_output);
         if (lane.valid_out) begin
            obs_words.push_back(lane.data_output);
            obs_vtimes.push_back(t);
         end
         if (lane.error) obs_nerr++;
         if (lane.active && obs_first_act < 0) obs_first_act = t;
         @(negedge clk_32f);
      end
      run_model();
      for (int t = 0; t < seg_bits.size(); t++) begin
         chk($sformatf("%s flags@%0d", name, t), 32'(obs_flags[t]), 32'(exp_flags[t]));
         chk($sformatf("%s data@%0d", name, t), obs_data[t], exp_data[t]);
      end
   endtask

   task automatic chk_words(input string name, input logic [31:0] w0, input logic [31:0] w1, input int n);
      chk({name, " nwords"}, 32'(obs_words.size()), 32'(n));
      if (n > 0 && obs_words.size() > 0) chk({name, " word0"}, obs_words[0], w0);
      if (n > 1 && obs_words.size() > 1) chk({name, " word1"}, obs_words[1], w1);
   endtask

   initial begin
      logic [7:0] rb;
      int         nj;
      int         ni;
      lane.data_in = 1'b0;

      // Junk bits, lock, two back-to-back words
      seg_bits.delete();
      seg_bits.push_back(1'b1); seg_bits.push_back(1'b0); seg_bits.push_back(1'b1);
      push_commas(4);
      push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hEE); push_byte(8'hEE);
      push_byte(8'hAD); push_byte(8'hFE); push_byte(8'hBA); push_byte(8'h01);
      push_byte(BC);
      run_segment("lock");
      chk("lock act_rise", 32'(obs_first_act), 32'd34);
      chk_words("lock", 32'hFFFFEEEE, 32'hADFEBA01, 2);
      if (obs_vtimes.size() == 2) chk("lock gap", 32'(obs_vtimes[1] - obs_vtimes[0]), 32'd32);
      else chk("lock gap_count", 32'(obs_vtimes.size()), 32'd2);

      // Three commas then a zero byte never locks
      seg_bits.delete();
      seg_bits.push_back(1'b1); seg_bits.push_back(1'b0); seg_bits.push_back(1'b1);
      push_commas(3);
      push_byte(8'h00); push_byte(8'h00);
      run_segment("nolock");
      chk("nolock active", 32'(obs_first_act), 32'hFFFFFFFF);

      // Comma inside a partial word
      seg_bits.delete();
      push_commas(4);
      push_byte(8'hAA); push_byte(8'hAA); push_byte(BC);
      push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
      run_segment("partial");
      chk("partial nerr", 32'(obs_nerr), 32'd1);
      chk_words("partial", 32'h12345678, 32'h0, 1);

      // Idle commas between words
      seg_bits.delete();
      push_commas(4);
      push_byte(8'hFA); push_byte(8'hFA); push_byte(8'hFA); push_byte(8'h01);
      push_commas(2);
      push_byte(8'hFA); push_byte(8'hFA); push_byte(8'hFA); push_byte(8'h01);
      push_byte(BC);
      run_segment("idle");
      chk("idle nerr", 32'(obs_nerr), 32'd0);
      chk_words("idle", 32'hFAFAFA01, 32'hFAFAFA01, 2);

      // Reset lands after two data bytes, then re-lock
      seg_bits.delete();
      push_commas(4);
      push_byte(8'h11); push_byte(8'h22);
      run_segment("midrst");
      chk("midrst nwords", 32'(obs_words.size()), 32'd0);
      seg_bits.delete();
      push_commas(4);
      push_byte(8'hBB); push_byte(8'hBB); push_byte(8'hAA); push_byte(8'hAA);
      run_segment("relock");
      chk_words("relock", 32'hBBBBAAAA, 32'h0, 1);

      // Random junk, comma runs of varying length, mixed data and idles
      for (int s = 0; s < 16; s++) begin
         seg_bits.delete();
         nj = $urandom_range(0, 20);
         for (int i = 0; i < nj; i++) seg_bits.push_back(1'($urandom_range(0, 1)));
         push_commas($urandom_range(BC_COUNT - 1, BC_COUNT + 1));
         ni = $urandom_range(10, 36);
         for (int i = 0; i < ni; i++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rb = BC;
            push_byte(rb);
         end
         run_segment($sformatf("rnd%0d", s));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
